// File: rtl/mul_pkg.sv
// mul_pkg: shared constants, FSM encoding and helpers for the multiplier-sharing
// controller (mul_share_ctrl) and its round-robin arbiter.
package mul_pkg;

    localparam int unsigned DEF_OP_W  = 32;
    localparam int unsigned DEF_RES_W = 2 * DEF_OP_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Width of a down-counter that must hold the value lat.
    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat + 1 > 2) ? $clog2(lat + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Searches req upward from rr_ptr,
// wrapping NREQ-1 -> 0, and returns the first set bit.
//   req      in  NREQ      request vector
//   rr_ptr   in  log2 NREQ highest-priority index
//   grant_c  out NREQ      one-hot grant (zero when req is zero)
//   gnt_id_c out log2 NREQ encoded grant index
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] rr_ptr,
    output logic [NREQ-1:0]         grant_c,
    output logic [$clog2(NREQ)-1:0] gnt_id_c
);

    localparam int unsigned ID_W  = $clog2(NREQ);
    localparam int unsigned SUM_W = ID_W + 1;

    logic [SUM_W-1:0] sum;
    logic [ID_W-1:0]  idx;
    logic             found;

    // Modulo-NREQ walk so non-power-of-two NREQ wraps correctly.
    always_comb begin
        grant_c  = '0;
        gnt_id_c = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sum = SUM_W'(rr_ptr) + SUM_W'(k);
            if (sum >= SUM_W'(NREQ)) begin
                sum = sum - SUM_W'(NREQ);
            end
            idx = ID_W'(sum);
            if (!found && req[idx]) begin
                found        = 1'b1;
                grant_c[idx] = 1'b1;
                gnt_id_c     = idx;
            end
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: shares one fixed-latency signed multiplier between NREQ
// requesters. Round-robin grant in IDLE, wait MUL_LAT cycles in BUSY, hold the
// product in RESP until the granted requester accepts it.
// Optional feature macro: MUL_ZERO_BYPASS_EN (a zero operand skips the
// multiplier and answers 0 one cycle after the handshake).
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_a/req_b   per-requester operand channel (packed)
//   rsp_valid/rsp_ready/rsp_res/rsp_ovf response channel, result shared
//   mul_a/mul_b/mul_enable/mul_res/mul_ovf multiplier interface
//   busy                               high whenever not IDLE
module mul_share_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned OP_W    = DEF_OP_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OP_W-1:0] req_a,
    input  logic [NREQ*OP_W-1:0] req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [2*OP_W-1:0]    rsp_res,
    output logic                 rsp_ovf,
    output logic [OP_W-1:0]      mul_a,
    output logic [OP_W-1:0]      mul_b,
    output logic                 mul_enable,
    input  logic [2*OP_W-1:0]    mul_res,
    input  logic                 mul_ovf,
    output logic                 busy
);

    localparam int unsigned ID_W  = $clog2(NREQ);
    localparam int unsigned RES_W = 2 * OP_W;
    localparam int unsigned CNT_W = cnt_width(MUL_LAT);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   a_q, a_d;
    logic [OP_W-1:0]   b_q, b_d;
    logic [RES_W-1:0]  rsp_res_q, rsp_res_d;
    logic              rsp_ovf_q, rsp_ovf_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic              mul_enable_q, mul_enable_d;
    logic              busy_q, busy_d;

    logic [NREQ-1:0]   arb_grant;
    logic [ID_W-1:0]   arb_id;
    logic [OP_W-1:0]   sel_a;
    logic [OP_W-1:0]   sel_b;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req      (req_valid),
        .rr_ptr   (rr_ptr_q),
        .grant_c  (arb_grant),
        .gnt_id_c (arb_id)
    );

    // Accept only in IDLE; the arbiter grant is zero when nobody is valid.
    assign req_ready = (state_q == IDLE) ? arb_grant : '0;

    assign sel_a = req_a[arb_id*OP_W +: OP_W];
    assign sel_b = req_b[arb_id*OP_W +: OP_W];

    assign rsp_valid  = rsp_valid_q;
    assign rsp_res    = rsp_res_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign mul_enable = mul_enable_q;
    assign busy       = busy_q;

    // State register and datapath flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            gnt_id_q     <= '0;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_res_q    <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_valid_q  <= '0;
            mul_enable_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_id_q     <= gnt_id_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_res_q    <= rsp_res_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_valid_q  <= rsp_valid_d;
            mul_enable_q <= mul_enable_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_id_d     = gnt_id_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_res_d    = rsp_res_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_valid_d  = rsp_valid_q;
        mul_enable_d = mul_enable_q;
        busy_d       = busy_q;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    a_d      = sel_a;
                    b_d      = sel_b;
                    gnt_id_d = arb_id;
                    busy_d   = 1'b1;
`ifdef MUL_ZERO_BYPASS_EN
                    if ((sel_a == '0) || (sel_b == '0)) begin
                        // Product is trivially zero; never wake the multiplier.
                        rsp_res_d   = '0;
                        rsp_ovf_d   = 1'b0;
                        rsp_valid_d = arb_grant;
                        state_d     = RESP;
                    end else begin
                        cnt_d        = CNT_W'(MUL_LAT);
                        mul_enable_d = 1'b1;
                        state_d      = BUSY;
                    end
`else
                    cnt_d        = CNT_W'(MUL_LAT);
                    mul_enable_d = 1'b1;
                    state_d      = BUSY;
`endif
                end
            end

            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rsp_res_d    = mul_res;
                    rsp_ovf_d    = mul_ovf;
                    rsp_valid_d  = NREQ'(1) << gnt_id_q;
                    mul_enable_d = 1'b0;
                    state_d      = RESP;
                end
            end

            RESP: begin
                if (rsp_ready[gnt_id_q]) begin
                    rr_ptr_d    = (gnt_id_q == ID_W'(NREQ - 1)) ? '0
                                                                : gnt_id_q + ID_W'(1);
                    rsp_valid_d = '0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                rsp_valid_d  = '0;
                mul_enable_d = 1'b0;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl: scoreboard bench for mul_share_ctrl (NREQ=4, MUL_LAT=2).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and
// compares them whenever a response is presented.
module tb_mul_share_ctrl;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned OP_W    = 32;
`ifdef MUL_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = MUL_LAT + 1;
`endif
    localparam int LAT = MUL_LAT + 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*OP_W-1:0] req_a;
    logic [NREQ*OP_W-1:0] req_b;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [2*OP_W-1:0]    rsp_res;
    logic                 rsp_ovf;
    logic [OP_W-1:0]      mul_a;
    logic [OP_W-1:0]      mul_b;
    logic                 mul_enable;
    logic [2*OP_W-1:0]    mul_res;
    logic                 mul_ovf;
    logic                 busy;

    mul_share_ctrl #(
        .NREQ    (NREQ),
        .MUL_LAT (MUL_LAT),
        .OP_W    (OP_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_res    (rsp_res),
        .rsp_ovf    (rsp_ovf),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_enable (mul_enable),
        .mul_res    (mul_res),
        .mul_ovf    (mul_ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stand-in: one register stage under enable (latency 2 from
    // enable), poisoned output when not enabled so early sampling shows up.
    logic signed [63:0] prod_c;
    assign prod_c = $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
    always @(posedge clk) begin
        if (mul_enable) begin
            mul_res <= prod_c;
            mul_ovf <= !((&prod_c[63:31]) || (~|prod_c[63:31]));
        end else begin
            mul_res <= 64'hDEAD_BEEF_DEAD_BEEF;
            mul_ovf <= 1'b1;
        end
    end

    typedef struct {
        int          id;
        logic [63:0] res;
        logic        ovf;
        int          t_valid;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   seen = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int id);
        logic [NREQ-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Response monitor.
    exp_t cur;
    always @(negedge clk) begin
        if (reset === 1'b1 && rsp_valid != '0) begin
            if (sb.size() == 0) begin
                check("spurious_rsp_valid", 64'(rsp_valid), 64'd0);
            end else begin
                cur = sb[0];
                if (!seen) begin
                    check("rsp_latency", 64'(cyc), 64'(cur.t_valid));
                    seen = 1'b1;
                end
                check("rsp_valid", 64'(rsp_valid), 64'(onehot(cur.id)));
                check("rsp_res", rsp_res, cur.res);
                check("rsp_ovf", 64'(rsp_ovf), 64'(cur.ovf));
                check("req_ready_in_resp", 64'(req_ready), 64'd0);
                if (rsp_ready[cur.id]) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[id*OP_W +: OP_W] = a;
        req_b[id*OP_W +: OP_W] = b;
        req_valid[id] = 1'b1;
    endtask

    task automatic push(input int id, input logic [63:0] res, input logic ovf, input int t);
        exp_t e;
        e.id = id; e.res = res; e.ovf = ovf; e.t_valid = t;
        sb.push_back(e);
    endtask

    task automatic wait_grant(input int id);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("grant", 64'(req_ready), 64'(onehot(id)));
    endtask

    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] res, input logic ovf, input int lat);
        set_req(id, a, b);
        wait_grant(id);
        push(id, res, ovf, cyc + lat);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_res", rsp_res, 64'd0);
        check("rst_rsp_ovf", 64'(rsp_ovf), 64'd0);
        check("rst_mul_a", 64'(mul_a), 64'd0);
        check("rst_mul_b", 64'(mul_b), 64'd0);
        check("rst_mul_enable", 64'(mul_enable), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // No requests: stay idle.
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_mul_enable", 64'(mul_enable), 64'd0);

        // Single requests through every requester.
        issue(0, 32'd3, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0, LAT);
        drain();
        issue(1, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1, LAT);
        drain();
        issue(2, 32'd0, 32'h1234_5678, 64'd0, 1'b0, ZLAT);
        drain();

        // Requester 3 served (-7 * -6); requester 1 shows up and drops out.
        set_req(3, 32'hFFFF_FFF9, 32'hFFFF_FFFA);
        wait_grant(3);
        push(3, 64'd42, 1'b0, cyc + LAT);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        set_req(1, 32'd1, 32'd1);
        @(posedge clk); #1;
        check("req_ready_while_busy", 64'(req_ready), 64'd0);
        req_valid[1] = 1'b0;
        drain();
        repeat (6) begin
            @(negedge clk);
            check("dropped_req_no_grant", 64'(req_ready), 64'd0);
        end

        // All four valid: rotating service 0,1,2,3.
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 32'(i + 1), 32'd10);
        end
        for (int k = 0; k < 4; k++) begin
            wait_grant(k);
            push(k, 64'((k + 1) * 10), 1'b0, cyc + LAT);
            @(posedge clk); #1;
            req_valid[k] = 1'b0;
        end
        drain();

        // Pointer wrapped to 0: requester 0 wins over 3.
        set_req(0, 32'd7, 32'hFFFF_FFFF);
        set_req(3, 32'd2, 32'd2);
        wait_grant(0);
        push(0, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, cyc + LAT);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_grant(3);
        push(3, 64'd4, 1'b0, cyc + LAT);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        drain();

        // Backpressure on requester 2 for 5 cycles; requester 0 waits.
        rsp_ready[2] = 1'b0;
        set_req(2, 32'hFFFF_FFFD, 32'h7FFF_FFFF);
        wait_grant(2);
        push(2, 64'hFFFF_FFFE_8000_0003, 1'b1, cyc + LAT);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        set_req(0, 32'd5, 32'hFFFF_FFFF);
        n = 0;
        @(negedge clk);
        while (!rsp_valid[2] && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("bp_busy", 64'(busy), 64'd1);
        check("bp_pending", 64'(sb.size()), 64'd1);
        @(posedge clk); #1;
        rsp_ready[2] = 1'b1;
        @(posedge clk); #1;
        check("idle_after_rsp", 64'(busy), 64'd0);
        check("grant_after_bp", 64'(req_ready), 64'(onehot(0)));
        push(0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, cyc + LAT);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        drain();

        // Reset in the last BUSY cycle aborts the operation.
        set_req(3, 32'd9, 32'd9);
        wait_grant(3);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_mul_enable", 64'(mul_enable), 64'd0);
        check("abort_mul_a", 64'(mul_a), 64'd0);
        check("abort_mul_b", 64'(mul_b), 64'd0);
        check("abort_rsp_res", rsp_res, 64'd0);
        check("abort_rsp_ovf", 64'(rsp_ovf), 64'd0);
        check("abort_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("no_rsp_after_abort", 64'(rsp_valid), 64'd0);
        end

        // Pointer restarts at 0 after reset.
        @(posedge clk); #1;
        set_req(0, 32'd6, 32'd7);
        set_req(1, 32'd2, 32'd3);
        wait_grant(0);
        push(0, 64'd42, 1'b0, cyc + LAT);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_grant(1);
        push(1, 64'd6, 1'b0, cyc + LAT);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        drain();

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
- Controller that shares one signed 32x32 multiplier instance (registered inputs and outputs, fixed latency) between NREQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and picks one requester by round-robin.
- Drives the multiplier operands and enable, waits the multiplier latency, then returns the 64-bit product and overflow flag to the granted requester over a valid/ready response channel.
- Sits between the ALU-side requesters and the multiplier datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MUL_LAT, 2, clock cycles from mul_enable assertion to a valid mul_res (>=1).
- OP_W, 32, operand width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_a  in  NREQ*OP_W  packed operand A; requester i occupies bits [i*OP_W +: OP_W].
- req_b  in  NREQ*OP_W  packed operand B, same packing as req_a.
- rsp_valid  out  NREQ  one-hot response valid.
- rsp_ready  in  NREQ  per-requester response accept.
- rsp_res  out  2*OP_W  signed product, shared by all requesters.
- rsp_ovf  out  1  overflow flag from the multiplier.
- mul_a  out  OP_W  multiplier operand A.
- mul_b  out  OP_W  multiplier operand B.
- mul_enable  out  1  multiplier input-capture enable.
- mul_res  in  2*OP_W  multiplier product.
- mul_ovf  in  1  multiplier overflow flag.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, rr_ptr=0, cnt=0, req_ready=0, rsp_valid=0, rsp_res=0, rsp_ovf=0, mul_a=0, mul_b=0, mul_enable=0, busy=0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, searching from rr_ptr upward with wrap NREQ-1 -> 0.
  - req_ready[grant]=1 combinationally, only in IDLE and only when some req_valid is set.
  - On handshake: register a, b and gnt_id; drive mul_a/mul_b from these registers; cnt=MUL_LAT; go to BUSY.
- BUSY:
  - mul_enable=1; mul_a and mul_b held stable; cnt decrements each cycle.
  - When cnt==1: capture mul_res into rsp_res and mul_ovf into rsp_ovf, then go to RESP.
- RESP:
  - rsp_valid[gnt_id]=1; rsp_res and rsp_ovf held stable until rsp_ready[gnt_id]=1.
  - On response handshake: rr_ptr=(gnt_id+1) mod NREQ; go to IDLE.
  - rsp_ready from non-granted requesters is ignored.
- Latency: handshake at cycle T -> rsp_valid asserted at cycle T+MUL_LAT+1. Minimum issue interval is MUL_LAT+2 cycles (with rsp_ready tied high).
- Requester rules:
  - req_a, req_b and req_valid must stay stable while req_valid=1 and req_ready=0.
  - Dropping req_valid before the handshake is legal; no grant results.
- Boundaries:
  - No req_valid in IDLE: stay in IDLE, outputs idle.
  - All requesters valid: served in rotating order starting at rr_ptr; no starvation.
  - rr_ptr wraps from NREQ-1 to 0.
  - A new request arriving during BUSY or RESP waits; req_ready stays 0.
  - Reset asserted mid-BUSY or mid-RESP: operation aborted, no response issued, all outputs return to reset values.
  - Signed arithmetic is performed entirely by the multiplier; the controller passes bits through unmodified.

Optional Feature:
- Macro: MUL_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, a granted request with req_a==0 or req_b==0 goes directly to RESP with rsp_res=0 and rsp_ovf=0.
  - mul_enable is never asserted for that request; latency is 1 cycle.
- Undefined: every request passes through BUSY.

Decomposition:
- Package mul_pkg:
  - OP_W default and RES_W=2*OP_W.
  - state encoding: IDLE=2'd0, BUSY=2'd1, RESP=2'd2.
  - counter width function clog2(MUL_LAT+1).
- Sub-module rr_arbiter:
  - Inputs: NREQ-bit request vector, rr_ptr.
  - Outputs: one-hot grant and encoded gnt_id.
  - Purely combinational.

Test Plan:
- Single request: requester 0 sends a=3, b=-4 (0xFFFFFFFC) -> rsp_valid[0] at T+MUL_LAT+1 with rsp_res=0xFFFF_FFFF_FFFF_FFF4, rsp_ovf equal to mul_ovf.
- All four requesters valid at once with a=i+1, b=10 -> grants in order 0,1,2,3; results 10,20,30,40; the next grant returns to 0 (wrap).
- Backpressure: rsp_ready[2] held low for 5 cycles -> rsp_valid[2], rsp_res and rsp_ovf stable; req_ready=0 for all requesters throughout; IDLE entered on the cycle after rsp_ready[2]=1.
- Reset pulse mid-BUSY (cnt=1) -> all outputs return to reset values immediately; no rsp_valid follows; the next request is granted from rr_ptr=0.
- Requester 1 drops req_valid while requester 3 is being served -> requester 1 is not granted later; requester 3 response correct (a=-7, b=-6 -> 42).
- MUL_ZERO_BYPASS_EN defined, a=0, b=0x12345678 -> rsp_valid one cycle after the handshake, rsp_res=0, mul_enable never asserted; undefined -> latency MUL_LAT+1.
